alu_issue_ctrl: RTL and testbench

//  Issue/sequencing stage directly upstream of the ALU. Buffers incoming ALU operations
//  (opcode, two 32-bit operands, tag) in a small FIFO. Presents one op at a time on the
//  ALU opcode/a/b/enable inputs and holds it stable for ALU_LAT cycles. Then samples the
//  ALU bus output and returns it with the tag over a valid/ready result port.

---
 rtl/alu_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the ALU.
// Ops are queued in a small FIFO and issued one at a time. Each op is held on
// the ALU inputs for ALU_LAT cycles, and the ALU result is then returned with
// its tag on a valid/ready port. Opcodes 16..31 are not sent to the ALU. They
// return an error result with zero data.
module alu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_opcode,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [4:0]               alu_opcode,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic                     alu_enable,
  input  logic [31:0]              alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_reg;
  logic [LW-1:0]    lat_cnt_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic [4:0]       op_mem  [DEPTH];
  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic             push;
  logic             pop;
  logic [4:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [TAG_W-1:0] head_tag;

  assign in_ready   = (count_reg != CW'(DEPTH));
  assign fifo_count = count_reg;
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);

  assign head_op    = op_mem[rd_ptr_reg];
  assign head_a     = a_mem[rd_ptr_reg];
  assign head_b     = b_mem[rd_ptr_reg];
  assign head_tag   = tag_mem[rd_ptr_reg];

  // FIFO storage. There is no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_reg]  <= in_opcode;
      a_mem[wr_ptr_reg]   <= in_a;
      b_mem[wr_ptr_reg]   <= in_b;
      tag_mem[wr_ptr_reg] <= in_tag;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (!push && pop) count_reg <= count_reg - CW'(1);
    end
  end

  // Issue FSM. All ALU-side and result-side outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_enable  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_tag     <= '0;
      res_err     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            res_tag <= head_tag;
            if (!head_op[4]) begin
              alu_opcode  <= head_op;
              alu_a       <= head_a;
              alu_b       <= head_b;
              alu_enable  <= 1'b1;
              lat_cnt_reg <= LW'(ALU_LAT - 1);
              state_reg   <= EXEC;
            end else begin
              // An illegal op never reaches the ALU. It goes straight to an error result.
              res_data  <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        EXEC: begin
          if (lat_cnt_reg != '0) begin
            lat_cnt_reg <= lat_cnt_reg - LW'(1);
          end else begin
            res_data   <= alu_out;
            res_err    <= 1'b0;
            alu_enable <= 1'b0;
            res_valid  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl.
// Directed table vectors, hand-written multi-cycle sequences, and randomized
// traffic, all checked against a queue-based reference of expected results.
module tb_alu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
  localparam int TAG_W   = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opcode;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [4:0]       alu_opcode;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_enable;
  logic [31:0]      alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic [2:0]       fifo_count;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU used both as the DUT's ALU and as the reference.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return a + b + {27'd0, op};
    endcase
  endfunction

  assign alu_out = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of expected results in acceptance order.
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t             mq[$];
  int               en_cycles = 0;
  int               delivered = 0;
  logic             prev_hold = 1'b0;
  logic [31:0]      prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_err;

  // Monitor. It samples on the falling edge, scoreboards every accepted result,
  // and checks that results stay stable under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      en_cycles = 0;
      prev_hold = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.err  = in_opcode[4];
        e.data = in_opcode[4] ? 32'd0 : alu_fn(in_opcode, in_a, in_b);
        e.tag  = in_tag;
        mq.push_back(e);
      end
      if (alu_enable) en_cycles++;
      if (prev_hold) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", res_data, prev_data);
        chk("hold_tag", 32'(res_tag), 32'(prev_tag));
        chk("hold_err", 32'(res_err), 32'(prev_err));
      end
      if (res_valid && res_ready) begin
        if (mq.size() == 0) begin
          chk("unexpected_result", 32'(res_tag), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = mq.pop_front();
          chk("sb_data", res_data, e.data);
          chk("sb_tag", 32'(res_tag), 32'(e.tag));
          chk("sb_err", 32'(res_err), 32'(e.err));
          chk("sb_en_cycles", 32'(en_cycles), e.err ? 32'd0 : 32'(ALU_LAT));
        end
        delivered++;
        en_cycles = 0;
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      prev_tag  = res_tag;
      prev_err  = res_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int n;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  task automatic run_random(input int nops, input int tag0);
    int  d0;
    bit  done;
    d0   = delivered;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < nops; i++) begin
          logic [4:0] op;
          op = ($urandom_range(0, 3) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
          push(op, $urandom, $urandom, TAG_W'(tag0 + i));
          if ($urandom_range(0, 2) == 0) tick();
        end
        drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b0;
    chk("random_delivered", 32'(delivered - d0), 32'(nops));
  endtask

  typedef struct {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd0,  32'd5,          32'd7,          4'd3,  32'd12,          1'b0};
    vecs[1] = '{5'd1,  32'd10,         32'd3,          4'd5,  32'd7,           1'b0};
    vecs[2] = '{5'd2,  32'h0000_F0F0,  32'h0000_FF00,  4'd6,  32'h0000_F000,   1'b0};
    vecs[3] = '{5'd3,  32'h0000_000F,  32'h0000_00F0,  4'd7,  32'h0000_00FF,   1'b0};
    vecs[4] = '{5'd4,  32'h0000_00FF,  32'h0000_000F,  4'd8,  32'h0000_00F0,   1'b0};
    vecs[5] = '{5'd20, 32'd1,          32'd2,          4'd9,  32'd0,           1'b1};
    vecs[6] = '{5'd9,  32'd100,        32'd200,        4'd10, 32'd309,         1'b0};
    vecs[7] = '{5'd31, 32'hFFFF_FFFF,  32'd1,          4'd15, 32'd0,           1'b1};
    vecs[8] = '{5'd1,  32'd0,          32'd1,          4'd0,  32'hFFFF_FFFF,   1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_enable", 32'(alu_enable), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven single ops. Result is checked while held, then accepted.
    for (int i = 0; i < 9; i++) begin
      res_ready = 1'b0;
      push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_valid();
      chk($sformatf("vec%0d_data", i), res_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_tag", i), 32'(res_tag), 32'(vecs[i].tag));
      chk($sformatf("vec%0d_err", i), 32'(res_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_en_cycles", i), 32'(en_cycles), vecs[i].exp_err ? 32'd0 : 32'(ALU_LAT));
      tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end

    // Backpressure: the result holds for 10 cycles and the next op waits in the FIFO.
    push(5'd0, 32'd1, 32'd2, 4'd1);
    push(5'd0, 32'd40, 32'd2, 4'd2);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", res_data, 32'd3);
      chk("bp_tag", 32'(res_tag), 32'd1);
      chk("bp_no_issue", 32'(alu_enable), 32'd0);
      chk("bp_fifo_count", 32'(fifo_count), 32'd1);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_en_before_take", 32'(alu_enable), 32'd0);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_valid", 32'(res_valid), 32'd0);
    chk("bp_idle_en", 32'(alu_enable), 32'd0);
    @(negedge clk);
    chk("bp_issue_en", 32'(alu_enable), 32'd1);
    chk("bp_issue_a", alu_a, 32'd40);
    wait_valid();
    chk("bp_second_data", res_data, 32'd42);
    chk("bp_second_tag", 32'(res_tag), 32'd2);
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Fill: five back-to-back pushes leave the head in flight and four queued.
    for (int i = 0; i < 5; i++) push(5'd0, 32'(i), 32'd100, TAG_W'(i));
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_opcode = 5'd2; in_a = 32'hFFFF; in_b = 32'h00FF; in_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fill_blocked_count", 32'(fifo_count), 32'd4);
    end
    tick();
    in_valid = 1'b0;
    res_ready = 1'b1;
    push(5'd2, 32'hFFFF, 32'h00FF, 4'd5);
    drain();
    tick();
    tick();
    res_ready = 1'b0;

    // Reset in the middle of an op aborts it and empties the FIFO asynchronously.
    push(5'd0, 32'd9, 32'd9, 4'd4);
    push(5'd0, 32'd1, 32'd1, 4'd5);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!alu_enable && n < 50) begin
        n++;
        @(negedge clk);
      end
      chk("rst_mid_exec_seen", 32'(alu_enable), 32'd1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_alu_enable", 32'(alu_enable), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_fifo_count", 32'(fifo_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_result", 32'(res_valid), 32'd0);
    end
    res_ready = 1'b0;
    tick();

    // Ordering and wrap: random opcodes, tags 0..9, random backpressure.
    run_random(10, 0);
    run_random(40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
